// File: rtl/seq_restoring_divider.sv
// Iterative radix-2 restoring divider: one quotient bit per clock, valid/ready on both sides.
// Divide-by-zero takes one CALC cycle and returns all-ones quotient, low dividend bits as remainder.
module seq_restoring_divider #(
  parameter int DW = 32,
  parameter int VW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_by_zero
);

  localparam int CW = (DW > 1) ? $clog2(DW) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [VW-1:0] dsr;
  logic [DW-1:0] q_reg;
  logic [VW-1:0] r_reg;
  logic          dbz_reg;
  logic          zero_pend;

  logic [VW:0]   trial;
  logic [VW-1:0] diff;
  logic          ge;

  // q_reg starts as the dividend and is shifted out MSB-first while quotient bits enter at the LSB.
  assign trial = {r_reg, q_reg[DW-1]};
  assign ge    = trial >= {1'b0, dsr};
  assign diff  = trial[VW-1:0] - dsr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = CALC;
      end
      CALC: begin
        if (zero_pend || cnt == '0) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      dsr       <= '0;
      q_reg     <= '0;
      r_reg     <= '0;
      dbz_reg   <= 1'b0;
      zero_pend <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            q_reg     <= dividend;
            dsr       <= divisor;
            r_reg     <= '0;
            cnt       <= CW'(DW - 1);
            zero_pend <= (divisor == '0);
            dbz_reg   <= 1'b0;
          end
        end
        CALC: begin
          if (zero_pend) begin
            r_reg     <= q_reg[VW-1:0];
            q_reg     <= '1;
            dbz_reg   <= 1'b1;
            zero_pend <= 1'b0;
          end else begin
            q_reg <= {q_reg[DW-2:0], ge};
            r_reg <= ge ? diff : trial[VW-1:0];
            cnt   <= cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign quotient    = q_reg;
  assign remainder   = r_reg;
  assign div_by_zero = dbz_reg;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed and randomized self-checking bench for seq_restoring_divider (DW=32, VW=16).
module tb_seq_restoring_divider;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] dividend = '0;
  logic [15:0] divisor = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] quotient;
  logic [15:0] remainder;
  logic        div_by_zero;

  int checks = 0;
  int errors = 0;

  seq_restoring_divider #(.DW(32), .VW(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dividend   (dividend),
    .divisor    (divisor),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Presents one operand pair and returns at #1 after the accepting edge.
  task automatic accept_op(input logic [31:0] a, input logic [15:0] b);
    int n;
    n = 0;
    while (!in_ready && n < 200) begin
      tick;
      n++;
    end
    check("in_ready_wait", in_ready, 1);
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    tick;
    in_valid = 1'b0;
  endtask

  // Counts edges after the accept until out_valid is seen.
  task automatic wait_result(output int lat);
    lat = 0;
    while (!out_valid && lat < 200) begin
      tick;
      lat++;
    end
    check("out_valid_wait", out_valid, 1);
  endtask

  task automatic take_result;
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
  endtask

  task automatic run_div(input logic [31:0] a, input logic [15:0] b,
                         output logic [31:0] q, output logic [15:0] r,
                         output logic dbz, output int lat);
    accept_op(a, b);
    wait_result(lat);
    q   = quotient;
    r   = remainder;
    dbz = div_by_zero;
    take_result;
  endtask

  initial begin
    logic [31:0] q, a32;
    logic [15:0] r, b16;
    logic        dbz;
    int          lat;

    // reset state
    repeat (3) tick;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_quotient", quotient, 0);
    check("rst_remainder", remainder, 0);
    check("rst_dbz", div_by_zero, 0);
    rst = 1'b0;
    tick;

    // out_ready outside DONE is harmless
    out_ready = 1'b1;
    tick;
    check("idle_out_ready_valid", out_valid, 0);
    check("idle_out_ready_rdy", in_ready, 1);
    out_ready = 1'b0;

    // basic division and latency
    run_div(32'h0000_0064, 16'h0007, q, r, dbz, lat);
    check("t1_q", q, 32'h0000_000E);
    check("t1_r", r, 16'h0002);
    check("t1_dbz", dbz, 0);
    check("t1_lat", lat, 32);
    check("t1_drop", out_valid, 0);

    run_div(32'hFFFF_FFFF, 16'hFFFF, q, r, dbz, lat);
    check("t2a_q", q, 32'h0001_0001);
    check("t2a_r", r, 16'h0000);

    run_div(32'h0000_0005, 16'h0009, q, r, dbz, lat);
    check("t2b_q", q, 32'h0);
    check("t2b_r", r, 16'h5);

    run_div(32'h0000_0000, 16'h0003, q, r, dbz, lat);
    check("zero_q", q, 32'h0);
    check("zero_r", r, 16'h0);
    check("zero_lat", lat, 32);

    run_div(32'hDEAD_BEEF, 16'h0001, q, r, dbz, lat);
    check("one_q", q, 32'hDEAD_BEEF);
    check("one_r", r, 16'h0);

    // divide by zero
    run_div(32'h1234_5678, 16'h0000, q, r, dbz, lat);
    check("t3_q", q, 32'hFFFF_FFFF);
    check("t3_r", r, 16'h5678);
    check("t3_dbz", dbz, 1);
    check("t3_lat", lat, 1);

    // dbz flag clears on the next normal division
    run_div(32'h0000_0064, 16'h0007, q, r, dbz, lat);
    check("dbz_clear", dbz, 0);

    // held result with a competing request pending
    accept_op(32'h0000_0064, 16'h0007);
    wait_result(lat);
    in_valid = 1'b1;
    dividend = 32'h0000_0005;
    divisor  = 16'h0009;
    for (int i = 0; i < 5; i++) begin
      tick;
      check("t4_hold_valid", out_valid, 1);
      check("t4_hold_q", quotient, 32'h0000_000E);
      check("t4_hold_r", remainder, 16'h0002);
      check("t4_hold_rdy", in_ready, 0);
    end
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    check("t4_after_valid", out_valid, 0);
    check("t4_not_accepted", in_ready, 1);
    tick;
    in_valid = 1'b0;
    check("t4_accepted", in_ready, 0);
    wait_result(lat);
    check("t4_lat", lat, 32);
    check("t4_q", quotient, 32'h0);
    check("t4_r", remainder, 16'h5);
    take_result;

    // reset in the middle of a calculation
    accept_op(32'h0000_0064, 16'h0007);
    repeat (9) tick;
    rst = 1'b1;
    #1;
    check("t5_rst_valid", out_valid, 0);
    check("t5_rst_rdy", in_ready, 1);
    check("t5_rst_q", quotient, 0);
    tick;
    tick;
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick;
      if (out_valid) check("t5_stale_valid", out_valid, 0);
    end
    check("t5_idle_valid", out_valid, 0);
    run_div(32'h0000_0064, 16'h0007, q, r, dbz, lat);
    check("t5_q", q, 32'h0000_000E);
    check("t5_r", r, 16'h0002);
    check("t5_lat", lat, 32);

    // round trip: (a*b)/b
    for (int i = 0; i < 1000; i++) begin
      a32 = 32'($urandom_range(0, 65535));
      b16 = 16'($urandom_range(1, 65535));
      run_div(a32 * {16'h0, b16}, b16, q, r, dbz, lat);
      check("rt_q", q, a32);
      check("rt_r", r, 0);
    end

    // random pairs against native division
    for (int i = 0; i < 1000; i++) begin
      a32 = $urandom;
      b16 = (i % 4 == 0) ? 16'($urandom_range(1, 15)) : 16'($urandom_range(1, 65535));
      run_div(a32, b16, q, r, dbz, lat);
      check("rnd_q", q, a32 / {16'h0, b16});
      check("rnd_r", r, a32 % {16'h0, b16});
      check("rnd_dbz", dbz, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
